// File: rtl/multi_phase_traffic_controller.sv
// Multi-road traffic light sequencer: round-robin green service with
// rest-in-green, pedestrian walk phase, and flashing-amber fallback mode.
// Every lamp output comes straight from a flop.
module multi_phase_traffic_controller #(
  parameter int N_ROADS    = 4,
  parameter int GREEN_CYC  = 20,
  parameter int AMBER_CYC  = 4,
  parameter int ALLRED_CYC = 2,
  parameter int PED_CYC    = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [N_ROADS-1:0]         sensor,
  input  logic                       ped_req,
  output logic [N_ROADS-1:0]         green,
  output logic [N_ROADS-1:0]         amber,
  output logic [N_ROADS-1:0]         red,
  output logic                       walk,
  output logic [$clog2(N_ROADS)-1:0] active_road
);

  localparam int          AW   = $clog2(N_ROADS);
  localparam int unsigned NR   = N_ROADS;
  localparam int          M1   = (GREEN_CYC > AMBER_CYC) ? GREEN_CYC : AMBER_CYC;
  localparam int          M2   = (ALLRED_CYC > PED_CYC) ? ALLRED_CYC : PED_CYC;
  localparam int          CMAX = (M1 > M2) ? M1 : M2;
  localparam int          CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_ALL_RED,
    S_GREEN,
    S_AMBER,
    S_PED_WALK,
    S_FLASH
  } state_t;

  state_t              r_state, w_state_nx;
  logic [CW-1:0]       r_cnt, w_cnt_nx;
  logic [AW-1:0]       r_road, w_road_nx, w_sel;
  logic                r_ped, w_ped_nx;
  logic                r_flash, w_flash_nx;
  logic                w_expire, w_enter_walk, w_other, w_found;
  logic [N_ROADS-1:0]  w_mask;
  int unsigned         w_idx;
  logic [N_ROADS-1:0]  r_green, r_amber, r_red;
  logic [N_ROADS-1:0]  w_green_nx, w_amber_nx, w_red_nx;
  logic                r_walk, w_walk_nx;

  assign green       = r_green;
  assign amber       = r_amber;
  assign red         = r_red;
  assign walk        = r_walk;
  assign active_road = r_road;

  // Round-robin pick: first requesting road after the current one, current road last
  always_comb begin
    w_found = 1'b0;
    w_idx   = 0;
    w_sel   = AW'((32'(r_road) + 32'd1) % NR);
    for (int unsigned i = 1; i <= NR; i++) begin
      w_idx = (32'(r_road) + i) % NR;
      if (!w_found && sensor[AW'(w_idx)]) begin
        w_found = 1'b1;
        w_sel   = AW'(w_idx);
      end
    end
  end

  // Demand from any road other than the one currently being served
  always_comb begin
    w_mask         = sensor;
    w_mask[r_road] = 1'b0;
    w_other        = |w_mask;
  end

  // Next-state, counter reload and pedestrian latch
  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt - CW'(1);
    w_road_nx    = r_road;
    w_flash_nx   = r_flash;
    w_enter_walk = 1'b0;
    w_expire     = (r_cnt == CW'(1));
    if (!enable) begin
      if (r_state != S_FLASH) begin
        w_state_nx = S_FLASH;
        w_cnt_nx   = CW'(AMBER_CYC);
        w_flash_nx = 1'b1;
      end else if (w_expire) begin
        w_cnt_nx   = CW'(AMBER_CYC);
        w_flash_nx = ~r_flash;
      end
    end else begin
      unique case (r_state)
        S_ALL_RED: if (w_expire) begin
          if (r_ped) begin
            w_state_nx   = S_PED_WALK;
            w_cnt_nx     = CW'(PED_CYC);
            w_enter_walk = 1'b1;
          end else begin
            w_state_nx = S_GREEN;
            w_cnt_nx   = CW'(GREEN_CYC);
            w_road_nx  = w_sel;
          end
        end
        S_GREEN: if (w_expire) begin
          if (r_ped || w_other) begin
            w_state_nx = S_AMBER;
            w_cnt_nx   = CW'(AMBER_CYC);
          end else begin
            w_cnt_nx = CW'(GREEN_CYC);
          end
        end
        S_AMBER, S_PED_WALK: if (w_expire) begin
          w_state_nx = S_ALL_RED;
          w_cnt_nx   = CW'(ALLRED_CYC);
        end
        S_FLASH: begin
          w_state_nx = S_ALL_RED;
          w_cnt_nx   = CW'(ALLRED_CYC);
        end
        default: begin
          w_state_nx = S_ALL_RED;
          w_cnt_nx   = CW'(ALLRED_CYC);
        end
      endcase
    end
    w_ped_nx = ped_req | (r_ped & ~w_enter_walk);
  end

  // Lamp pattern decoded from the upcoming state so the lamps can be registered
  always_comb begin
    w_green_nx = '0;
    w_amber_nx = '0;
    w_red_nx   = '1;
    w_walk_nx  = 1'b0;
    unique case (w_state_nx)
      S_GREEN: begin
        w_green_nx[w_road_nx] = 1'b1;
        w_red_nx[w_road_nx]   = 1'b0;
      end
      S_AMBER: begin
        w_amber_nx[w_road_nx] = 1'b1;
        w_red_nx[w_road_nx]   = 1'b0;
      end
      S_PED_WALK: w_walk_nx = 1'b1;
      S_FLASH: begin
        w_red_nx   = '0;
        w_amber_nx = {N_ROADS{w_flash_nx}};
      end
      default: ;
    endcase
  end

  // State, timer and registered lamp outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_ALL_RED;
      r_cnt   <= CW'(ALLRED_CYC);
      r_road  <= AW'(N_ROADS - 1);
      r_ped   <= 1'b0;
      r_flash <= 1'b1;
      r_green <= '0;
      r_amber <= '0;
      r_red   <= '1;
      r_walk  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_road  <= w_road_nx;
      r_ped   <= w_ped_nx;
      r_flash <= w_flash_nx;
      r_green <= w_green_nx;
      r_amber <= w_amber_nx;
      r_red   <= w_red_nx;
      r_walk  <= w_walk_nx;
    end
  end

endmodule

// File: tb/tb_multi_phase_traffic_controller.sv
// Bench for multi_phase_traffic_controller: a phase/elapsed-time model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_multi_phase_traffic_controller;

  localparam int N  = 4;
  localparam int GC = 8;
  localparam int AC = 3;
  localparam int RC = 2;
  localparam int PC = 5;

  localparam int P_AR = 0;
  localparam int P_G  = 1;
  localparam int P_AM = 2;
  localparam int P_W  = 3;
  localparam int P_FL = 4;

  logic         clk;
  logic         rst;
  logic         enable;
  logic [N-1:0] sensor;
  logic         ped_req;
  logic [N-1:0] green, amber, red;
  logic         walk;
  logic [1:0]   active_road;

  int checks   = 0;
  int failures = 0;

  multi_phase_traffic_controller #(
    .N_ROADS   (N),
    .GREEN_CYC (GC),
    .AMBER_CYC (AC),
    .ALLRED_CYC(RC),
    .PED_CYC   (PC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .sensor     (sensor),
    .ped_req    (ped_req),
    .green      (green),
    .amber      (amber),
    .red        (red),
    .walk       (walk),
    .active_road(active_road)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: phase, cycles spent in it, served road, pending walk, flash level
  int m_phase, m_el, m_road, m_fel;
  bit m_ped, m_flash, m_valid;

  function automatic int dur(input int p);
    case (p)
      P_G:     return GC;
      P_AM:    return AC;
      P_W:     return PC;
      default: return RC;
    endcase
  endfunction

  function automatic int pick(input int cur, input logic [N-1:0] s);
    for (int k = 1; k <= N; k++) if (s[(cur + k) % N]) return (cur + k) % N;
    return (cur + 1) % N;
  endfunction

  always @(posedge clk) begin : model
    int ph, el, rd, fel;
    bit pd, fl, ew;
    logic [N-1:0] own;
    ph = m_phase; el = m_el; rd = m_road; pd = m_ped; fl = m_flash; fel = m_fel;
    ew = 1'b0;
    if (rst) begin
      ph = P_AR; el = 0; rd = N - 1; pd = 1'b0; fl = 1'b1; fel = 0;
    end else begin
      if (!enable) begin
        if (ph != P_FL) begin
          ph = P_FL; fl = 1'b1; fel = 0;
        end else begin
          fel++;
          if (fel == AC) begin fl = !fl; fel = 0; end
        end
      end else if (ph == P_FL) begin
        ph = P_AR; el = 0;
      end else begin
        el++;
        if (el == dur(ph)) begin
          el = 0;
          own = '0;
          own[rd] = 1'b1;
          case (ph)
            P_AR: if (pd) begin ph = P_W; ew = 1'b1; end
                  else begin rd = pick(rd, sensor); ph = P_G; end
            P_G:  if (pd || ((sensor & ~own) != '0)) ph = P_AM;
            default: ph = P_AR;
          endcase
        end
      end
      pd = ped_req || (pd && !ew);
    end
    m_phase <= ph; m_el <= el; m_road <= rd; m_ped <= pd; m_flash <= fl; m_fel <= fel;
    if (rst) m_valid <= 1'b1;
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin : compare
    logic [N-1:0] eg, ea, er;
    logic ew;
    if (m_valid) begin
      eg = '0; ea = '0; er = '1; ew = 1'b0;
      case (m_phase)
        P_G:  begin eg[m_road] = 1'b1; er[m_road] = 1'b0; end
        P_AM: begin ea[m_road] = 1'b1; er[m_road] = 1'b0; end
        P_W:  ew = 1'b1;
        P_FL: begin er = '0; ea = {N{m_flash}}; end
        default: ;
      endcase
      checks++;
      if (green !== eg || amber !== ea || red !== er || walk !== ew || active_road !== 2'(m_road)) begin
        failures++;
        $display("FAIL model t=%0t got g=%b a=%b r=%b w=%b road=%0d exp g=%b a=%b r=%b w=%b road=%0d",
                 $time, green, amber, red, walk, active_road, eg, ea, er, ew, m_road);
      end
    end
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic check_now(input string nm, input logic [N-1:0] g, a, r, input logic w);
    checks++;
    if (green !== g || amber !== a || red !== r || walk !== w) begin
      failures++;
      $display("FAIL %s got g=%b a=%b r=%b w=%b exp g=%b a=%b r=%b w=%b",
               nm, green, amber, red, walk, g, a, r, w);
    end
  endtask

  task automatic check_road(input string nm, input logic [1:0] rd);
    checks++;
    if (active_road !== rd) begin
      failures++;
      $display("FAIL %s got road=%0d exp road=%0d", nm, active_road, rd);
    end
  endtask

  task automatic hold(input string nm, input logic [N-1:0] g, a, r, input logic w, input int n);
    for (int i = 0; i < n; i++) begin
      check_now(nm, g, a, r, w);
      tick();
    end
  endtask

  task automatic wait_for(input string nm, input logic [N-1:0] g, a, r, input logic w, input int budget);
    int k = 0;
    while (!(green === g && amber === a && red === r && walk === w) && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (!(green === g && amber === a && red === r && walk === w)) begin
      failures++;
      $display("FAIL %s timeout after %0d cycles got g=%b a=%b r=%b w=%b exp g=%b a=%b r=%b w=%b",
               nm, budget, green, amber, red, walk, g, a, r, w);
    end
  endtask

  task automatic pulse_ped;
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; sensor = '0; ped_req = 1'b0;
    repeat (3) tick();

    // Reset state, then two all-red cycles and rest-in-green on road 0
    check_now("reset", 4'b0000, 4'b0000, 4'b1111, 1'b0);
    check_road("reset_road", 2'd3);
    rst = 1'b0;
    tick();
    check_now("allred_after_reset", 4'b0000, 4'b0000, 4'b1111, 1'b0);
    tick();
    check_now("first_green", 4'b0001, 4'b0000, 4'b1110, 1'b0);
    check_road("first_road", 2'd0);
    repeat (20) tick();
    check_now("rest_in_green", 4'b0001, 4'b0000, 4'b1110, 1'b0);

    // Demand on road 2 ends the rest-in-green
    sensor = 4'b0100;
    wait_for("s2_amber_start", 4'b0000, 4'b0001, 4'b1110, 1'b0, 12);
    hold("s2_amber", 4'b0000, 4'b0001, 4'b1110, 1'b0, AC);
    hold("s2_allred", 4'b0000, 4'b0000, 4'b1111, 1'b0, RC);
    check_now("s2_green", 4'b0100, 4'b0000, 4'b1011, 1'b0);
    check_road("s2_road", 2'd2);

    // Wrap-around order 3, 0, 1 starting from road 1
    sensor = 4'b0010;
    wait_for("s3_green1", 4'b0010, 4'b0000, 4'b1101, 1'b0, 30);
    check_road("s3_road1", 2'd1);
    sensor = 4'b1011;
    wait_for("s3_green3", 4'b1000, 4'b0000, 4'b0111, 1'b0, 20);
    check_road("s3_road3", 2'd3);
    wait_for("s3_green0", 4'b0001, 4'b0000, 4'b1110, 1'b0, 20);
    check_road("s3_road0", 2'd0);
    wait_for("s3_green1b", 4'b0010, 4'b0000, 4'b1101, 1'b0, 20);
    check_road("s3_road1b", 2'd1);

    // Pedestrian request during green on road 0
    sensor = 4'b0001;
    wait_for("s4_green0", 4'b0001, 4'b0000, 4'b1110, 1'b0, 30);
    sensor = 4'b0000;
    pulse_ped();
    wait_for("s4_amber_start", 4'b0000, 4'b0001, 4'b1110, 1'b0, 12);
    hold("s4_amber", 4'b0000, 4'b0001, 4'b1110, 1'b0, AC);
    hold("s4_allred1", 4'b0000, 4'b0000, 4'b1111, 1'b0, RC);
    hold("s4_walk", 4'b0000, 4'b0000, 4'b1111, 1'b1, PC);
    hold("s4_allred2", 4'b0000, 4'b0000, 4'b1111, 1'b0, RC);
    check_now("s4_green_next", 4'b0010, 4'b0000, 4'b1101, 1'b0);
    check_road("s4_road", 2'd1);

    // Flash mode entered mid-amber, then resumed
    sensor = 4'b0100;
    wait_for("s5_amber_start", 4'b0000, 4'b0010, 4'b1101, 1'b0, 12);
    enable = 1'b0;
    tick();
    hold("s5_flash_on", 4'b0000, 4'b1111, 4'b0000, 1'b0, AC);
    hold("s5_flash_off", 4'b0000, 4'b0000, 4'b0000, 1'b0, AC);
    check_now("s5_flash_on2", 4'b0000, 4'b1111, 4'b0000, 1'b0);
    enable = 1'b1;
    tick();
    hold("s5_allred", 4'b0000, 4'b0000, 4'b1111, 1'b0, RC);
    check_now("s5_green", 4'b0100, 4'b0000, 4'b1011, 1'b0);
    check_road("s5_road", 2'd2);

    // Reset in the middle of a walk with a request pending
    sensor = 4'b0000;
    pulse_ped();
    wait_for("s6_walk", 4'b0000, 4'b0000, 4'b1111, 1'b1, 20);
    tick();
    tick();
    ped_req = 1'b1;
    rst = 1'b1;
    tick();
    check_now("s6_reset", 4'b0000, 4'b0000, 4'b1111, 1'b0);
    check_road("s6_reset_road", 2'd3);
    rst = 1'b0;
    ped_req = 1'b0;
    tick();
    check_now("s6_allred", 4'b0000, 4'b0000, 4'b1111, 1'b0);
    tick();
    check_now("s6_green_no_walk", 4'b0001, 4'b0000, 4'b1110, 1'b0);
    check_road("s6_road", 2'd0);

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_phase_traffic_controller.md
MULTI_PHASE_TRAFFIC_CONTROLLER -- requirements
Module: multi_phase_traffic_controller

Interface
REQ-001 SHALL have parameter N_ROADS, default 4, number of approach roads served (legal 2..8).
REQ-002 SHALL have parameter GREEN_CYC, default 20, minimum green duration in clocks (>=1).
REQ-003 SHALL have parameter AMBER_CYC, default 4, amber duration in clocks (>=1); also the flash half-period.
REQ-004 SHALL have parameter ALLRED_CYC, default 2, all-red clearance duration in clocks (>=1).
REQ-005 SHALL have parameter PED_CYC, default 10, pedestrian walk duration in clocks (>=1).
REQ-006 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-008 SHALL have port enable  input  1  1 = normal sequencing, 0 = flashing-amber mode.
REQ-009 SHALL have port sensor  input  N_ROADS  per-road vehicle-present level, sampled each clock.
REQ-010 SHALL have port ped_req  input  1  pedestrian button; a 1-cycle pulse is sufficient.
REQ-011 SHALL have port green  output  N_ROADS  green lamp per road.
REQ-012 SHALL have port amber  output  N_ROADS  amber lamp per road.
REQ-013 SHALL have port red  output  N_ROADS  red lamp per road.
REQ-014 SHALL have port walk  output  1  pedestrian walk lamp.
REQ-015 SHALL have port active_road  output  clog2(N_ROADS)  index of the road currently or last served.
REQ-016 SHALL have all outputs driven directly from registers (no combinational path from inputs).

Function
REQ-017 SHALL implement states ALL_RED, GREEN, AMBER, PED_WALK, FLASH; each timed state lasts exactly its parameter's cycle count, tracked by an internal down-counter.
REQ-018 SHALL, in every state except FLASH, drive exactly one lamp per road one-hot across {green,amber,red}; only active_road may be non-red.
REQ-019 SHALL on ALL_RED expiry go to PED_WALK if ped_pending=1, else GREEN on the selected road.
REQ-020 SHALL select the next road round-robin: first i with sensor[i]=1 scanning active_road+1, +2, ... wrapping, active_road last; if no sensor set, active_road+1 mod N_ROADS.
REQ-021 SHALL on GREEN expiry go to AMBER if ped_pending=1 or any sensor[j]=1 with j!=active_road; otherwise reload GREEN_CYC and remain green (rest-in-green).
REQ-022 SHALL on AMBER expiry go to ALL_RED; on PED_WALK expiry go to ALL_RED with active_road unchanged.
REQ-023 SHALL in PED_WALK drive all red=1, green=0, amber=0, walk=1; walk=0 in all other states.
REQ-024 SHALL latch ped_req into ped_pending (set has priority over clear in the same cycle) and clear it on the cycle PED_WALK is entered.
REQ-025 SHALL, when enable=0 in any state, enter FLASH on the next clock: green=0, red=0, walk=0, all amber bits equal a flash bit toggling every AMBER_CYC cycles, starting at 1.
REQ-026 SHALL, when enable returns to 1 in FLASH, enter ALL_RED with ALLRED_CYC loaded and active_road unchanged; ped_pending is held through FLASH.
REQ-027 SHALL treat sensor changes mid-state as having no effect until the state's expiry cycle.

Reset
REQ-028 SHALL on rst=1 at a clock edge, regardless of state or enable, enter ALL_RED with counter=ALLRED_CYC, active_road=N_ROADS-1, ped_pending=0, flash bit=1.
REQ-029 SHALL drive after reset red=all ones, green=0, amber=0, walk=0, so that with no sensors road 0 is served first.
REQ-030 SHALL give rst priority over enable, sensor and ped_req.

Verification (bench params: N_ROADS=4, GREEN_CYC=8, AMBER_CYC=3, ALLRED_CYC=2, PED_CYC=5)
REQ-031 SHALL cover: reset, sensor=0 -> red=4'b1111 2 cycles, then green=4'b0001 for 8+ cycles and held indefinitely (rest-in-green).
REQ-032 SHALL cover: green on road 0, sensor=4'b0100 -> after 8 green, amber=4'b0001 3 cycles, red all 2 cycles, green=4'b0100, active_road=2.
REQ-033 SHALL cover: sensor=4'b1011 with active_road=1 -> next green road 3, then 0, then 1 (wrap-around order).
REQ-034 SHALL cover: 1-cycle ped_req during green road 0 -> amber 3, all-red 2, walk=1 for 5 with red=4'b1111, all-red 2, then next green.
REQ-035 SHALL cover: enable=0 mid-AMBER -> next cycle amber=4'b1111, toggling every 3 cycles; enable=1 -> ALL_RED 2 cycles then green resumes from the same active_road.
REQ-036 SHALL cover: rst asserted mid-PED_WALK with ped_req=1 -> next cycle walk=0, red=4'b1111, ped_pending=0.
